// File: rtl/rsa_decryption.sv
// RSA private-key engine: publishes a fixed multi-prime public key and decrypts
// M = C^D mod N with left-to-right square-and-multiply over a bit-serial modmul.
module rsa_decryption #(
  parameter int unsigned      WIDTH = 512,
  parameter logic [WIDTH-1:0] P     = 61,
  parameter logic [WIDTH-1:0] Q     = 53,
  parameter logic [WIDTH-1:0] R     = 1,
  parameter logic [WIDTH-1:0] S     = 1,
  parameter logic [WIDTH-1:0] E     = 17,
  parameter logic [WIDTH-1:0] D     = 2753
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [4*WIDTH-1:0]   In_Data_word,
  input  logic                 In_Data_Ready,
  input  logic                 New_RSA_Start,
  output logic [WIDTH-1:0]     Out_publicKey_exp,
  output logic [4*WIDTH-1:0]   Out_publicKey_mod,
  output logic                 ready_to_encryption,
  output logic [4*WIDTH-1:0]   Out_Data_word,
  output logic                 Decrypt_done
);

  localparam int unsigned DW = 4 * WIDTH;
  localparam int unsigned XW = DW + 2;
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [DW-1:0]    N  = DW'(P) * DW'(Q) * DW'(R) * DW'(S);
  localparam logic [XW-1:0]    NX = {2'b00, N};
  localparam logic [WIDTH-1:0] DK = D;

  function automatic int unsigned msb_of(input logic [WIDTH-1:0] v);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) m = i;
    end
    return m;
  endfunction

  // Leading zeros of D are skipped by starting the scan at its top set bit.
  localparam logic [IW-1:0] DMSB = IW'(msb_of(D));

  typedef enum logic [2:0] {S_IDLE, S_KEYS, S_LOAD, S_EXP, S_DONE} state_t;

  state_t            state_q;
  logic [DW-1:0]     c_q, r_q, a_q, b_q;
  logic [XW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic              busy_q, first_q, pend_mul_q;
  logic [WIDTH-1:0]  exp_q;
  logic [DW-1:0]     mod_q, data_q;
  logic              rte_q, done_q;

  // acc < N on entry, so 2*acc + a < 3N and two conditional subtracts suffice.
  always_comb begin
    acc_d = (acc_q << 1) + (b_q[DW-1] ? {2'b00, a_q} : '0);
    if (acc_d >= NX) acc_d = acc_d - NX;
    if (acc_d >= NX) acc_d = acc_d - NX;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      r_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      pend_mul_q <= 1'b0;
      exp_q      <= '0;
      mod_q      <= '0;
      rte_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (New_RSA_Start) begin
            exp_q   <= E;
            mod_q   <= N;
            rte_q   <= 1'b1;
            state_q <= S_KEYS;
          end
        end
        S_KEYS: begin
          if (In_Data_Ready) begin
            c_q     <= In_Data_word;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_q        <= {{(DW-1){1'b0}}, 1'b1};
          idx_q      <= DMSB;
          first_q    <= 1'b1;
          pend_mul_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_EXP;
        end
        S_EXP: begin
          if (busy_q) begin
            if (cnt_q != '0) begin
              acc_q <= acc_d;
              b_q   <= b_q << 1;
              cnt_q <= cnt_q - CW'(1);
            end else begin
              r_q    <= acc_q[DW-1:0];
              busy_q <= 1'b0;
            end
          end else if (first_q) begin
            r_q     <= c_q;
            first_q <= 1'b0;
          end else if (pend_mul_q) begin
            a_q        <= r_q;
            b_q        <= c_q;
            acc_q      <= '0;
            cnt_q      <= CW'(DW);
            busy_q     <= 1'b1;
            pend_mul_q <= 1'b0;
          end else if (idx_q == '0) begin
            data_q  <= r_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            // Square for the next lower bit; its multiply is queued behind it.
            idx_q      <= idx_q - IW'(1);
            pend_mul_q <= DK[idx_q - IW'(1)];
            a_q        <= r_q;
            b_q        <= r_q;
            acc_q      <= '0;
            cnt_q      <= CW'(DW);
            busy_q     <= 1'b1;
          end
        end
        S_DONE: begin
          if (!In_Data_Ready) begin
            done_q  <= 1'b0;
            state_q <= S_KEYS;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Out_publicKey_exp   = exp_q;
  assign Out_publicKey_mod   = mod_q;
  assign ready_to_encryption = rte_q;
  assign Out_Data_word       = data_q;
  assign Decrypt_done        = done_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Scoreboard bench for rsa_decryption with the textbook key (P=61, Q=53, E=17, D=2753).
module tb_rsa_decryption;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DW    = 4 * WIDTH;
  localparam int unsigned TMO   = 5000;

  logic             clk;
  logic             aresetn;
  logic [DW-1:0]    in_word;
  logic             in_ready;
  logic             new_start;
  logic [WIDTH-1:0] pk_exp;
  logic [DW-1:0]    pk_mod;
  logic             rte;
  logic [DW-1:0]    out_word;
  logic             done;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned dones    = 0;
  logic [DW-1:0] exp_q[$];

  rsa_decryption #(
    .WIDTH(WIDTH),
    .P(16'd61),
    .Q(16'd53),
    .R(16'd1),
    .S(16'd1),
    .E(16'd17),
    .D(16'd2753)
  ) dut (
    .aclk               (clk),
    .aresetn            (aresetn),
    .In_Data_word       (in_word),
    .In_Data_Ready      (in_ready),
    .New_RSA_Start      (new_start),
    .Out_publicKey_exp  (pk_exp),
    .Out_publicKey_mod  (pk_mod),
    .ready_to_encryption(rte),
    .Out_Data_word      (out_word),
    .Decrypt_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every rising Decrypt_done must match the oldest queued plaintext.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        dones++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got %0d expected no result", out_word);
        end else begin
          check("plaintext", out_word, exp_q.pop_front());
        end
      end
      prev = done;
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_exp"},  DW'(pk_exp), '0);
    check({name, "_mod"},  pk_mod, '0);
    check({name, "_rte"},  DW'(rte), '0);
    check({name, "_data"}, out_word, '0);
    check({name, "_done"}, DW'(done), '0);
  endtask

  task automatic publish();
    @(negedge clk);
    new_start = 1'b1;
    @(negedge clk);
    new_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no Decrypt_done expected done within %0d cycles", TMO);
    end
  endtask

  task automatic decrypt(input logic [DW-1:0] c, input logic [DW-1:0] m, input int unsigned hold);
    bit ok;
    exp_q.push_back(m);
    @(negedge clk);
    in_word  = c;
    in_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_word = 64'hDEAD_BEEF_0BAD_F00D;
    wait_done(ok);
    if (ok) begin
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge clk);
        check("done_held", DW'(done), 1);
      end
      in_ready = 1'b0;
      @(negedge clk);
      check("done_drop", DW'(done), 0);
      check("data_hold", out_word, m);
    end else begin
      in_ready = 1'b0;
    end
  endtask

  initial begin
    int unsigned d0;
    aresetn   = 1'b0;
    in_word   = '0;
    in_ready  = 1'b0;
    new_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Request before key published: ignored
    aresetn  = 1'b1;
    in_word  = 64'd2790;
    in_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_done", DW'(done), 0);
    check("idle_rte", DW'(rte), 0);
    in_ready = 1'b0;

    publish();
    check("pk_rte", DW'(rte), 1);
    check("pk_exp", DW'(pk_exp), 17);
    check("pk_mod", pk_mod, 3233);
    publish();
    check("pk2_rte", DW'(rte), 1);
    check("pk2_exp", DW'(pk_exp), 17);
    check("pk2_mod", pk_mod, 3233);

    decrypt(64'd2790, 64'd65, 0);
    decrypt(64'd1773, 64'd100, 0);   // 100^17 mod 3233 = 1773
    decrypt(64'd0, 64'd0, 0);
    decrypt(64'd1, 64'd1, 0);

    d0 = dones;
    decrypt(64'd2790, 64'd65, 10);
    check("single_run", DW'(dones - d0), 1);
    decrypt(64'd2790, 64'd65, 0);

    // Abort mid-exponentiation
    @(negedge clk);
    in_word  = 64'd2790;
    in_ready = 1'b1;
    repeat (200) @(negedge clk);
    aresetn  = 1'b0;
    in_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("abort");
    aresetn = 1'b1;
    publish();
    check("repub_rte", DW'(rte), 1);
    check("repub_mod", pk_mod, 3233);
    decrypt(64'd2790, 64'd65, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", DW'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
